// File: rtl/controlador_salida_conmutacion_if.sv
// Interface for the switching-output sequencer.
// master: the PWM/switching generator side, which drives the requests and the raw signal.
// slave:  the sequencer, which drives the demux select, the gate and the status outputs.
// The requests are plain level signals, not a valid/ready handshake. A requester keeps
// req[i] high for as long as it wants output i. The sequencer shows which channel it has
// accepted on grant.
interface controlador_salida_conmutacion_if;
    logic [1:0] req;
    logic       In_signal_conmutacion;
    logic       select_salida;
    logic       habilitar;
    logic       signal_conmutacion_out;
    logic [1:0] grant;
    logic       ocupado;
    logic [1:0] estado;   // debug view of the FSM state (0 IDLE, 1 DEAD, 2 ACTIVE)

    modport master (
        output req, In_signal_conmutacion,
        input  select_salida, habilitar, signal_conmutacion_out, grant, ocupado, estado
    );

    modport slave (
        input  req, In_signal_conmutacion,
        output select_salida, habilitar, signal_conmutacion_out, grant, ocupado, estado
    );
endinterface

// File: rtl/controlador_salida_conmutacion.sv
// Sequencer for the 1-to-2 switching-signal output demux.
// It arbitrates two channel requesters and drives the demux select. The switching signal
// is gated low during a dead time around every select change. Each grant is held for a
// minimum dwell time.
// Optional feature: define SALIDA_ROUND_ROBIN_EN to arbitrate round-robin. By default
// channel 0 has fixed priority.
module controlador_salida_conmutacion #(
    parameter int DEAD_TIME = 4,
    parameter int MIN_DWELL = 16,
    parameter int CW        = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    controlador_salida_conmutacion_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEAD   = 2'd1,
        ACTIVE = 2'd2
    } estado_t;

    localparam logic [CW-1:0] DEAD_INIT = CW'(DEAD_TIME - 1);
    localparam logic [CW-1:0] DWELL_MAX = CW'(MIN_DWELL - 1);

    estado_t       state_q, state_d;
    logic          sel_q, sel_d;
    logic          hab_q, hab_d;
    logic [1:0]    grant_q, grant_d;
    logic          ocup_q, ocup_d;
    logic [CW-1:0] dead_cnt_q, dead_cnt_d;
    logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic          last_grant_q, last_grant_d;

    logic          winner;
    logic          sel_otro;

    assign sel_otro = ~sel_q;

    // Arbitration winner. A single request wins outright; a contest uses the configured policy.
    always_comb begin
        winner = bus.req[1];
        if (bus.req == 2'b11) begin
`ifdef SALIDA_ROUND_ROBIN_EN
            winner = ~last_grant_q;
`else
            winner = 1'b0;
`endif
        end
    end

    // Next-state and next-output logic for the IDLE / DEAD / ACTIVE sequencer.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        hab_d        = hab_q;
        grant_d      = grant_q;
        ocup_d       = ocup_q;
        dead_cnt_d   = dead_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                hab_d   = 1'b0;
                grant_d = 2'b00;
                if (bus.req != 2'b00) begin
                    sel_d      = winner;
                    ocup_d     = 1'b1;
                    dead_cnt_d = DEAD_INIT;
                    state_d    = DEAD;
                end
            end
            DEAD: begin
                hab_d   = 1'b0;
                grant_d = 2'b00;
                ocup_d  = 1'b1;
                if (dead_cnt_q != '0) begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end else if (bus.req[sel_q]) begin
                    state_d      = ACTIVE;
                    hab_d        = 1'b1;
                    grant_d      = sel_q ? 2'b10 : 2'b01;
                    last_grant_d = sel_q;
                    dwell_cnt_d  = '0;
                    ocup_d       = 1'b0;
                end else if (bus.req[sel_otro]) begin
                    // The selected channel gave up during the dead time, so retarget the
                    // other channel. A full dead time starts again because select moves.
                    sel_d      = sel_otro;
                    dead_cnt_d = DEAD_INIT;
                end else begin
                    state_d = IDLE;
                    ocup_d  = 1'b0;
                end
            end
            ACTIVE: begin
                hab_d = 1'b1;
                if (dwell_cnt_q != DWELL_MAX) begin
                    // The minimum dwell is not over yet; ignore requests until it is.
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end else if (bus.req[sel_otro] && (winner == sel_otro)) begin
                    // Gate off and move select on the same edge. Gated output stays low
                    // through the following dead time.
                    hab_d      = 1'b0;
                    grant_d    = 2'b00;
                    sel_d      = sel_otro;
                    ocup_d     = 1'b1;
                    dead_cnt_d = DEAD_INIT;
                    state_d    = DEAD;
                end else if (bus.req == 2'b00) begin
                    hab_d   = 1'b0;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hab_d   = 1'b0;
                grant_d = 2'b00;
                ocup_d  = 1'b0;
            end
        endcase
    end

    // All sequencer state and registered outputs. Reset is asynchronous, so the gate drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            hab_q        <= 1'b0;
            grant_q      <= 2'b00;
            ocup_q       <= 1'b0;
            dead_cnt_q   <= '0;
            dwell_cnt_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            hab_q        <= hab_d;
            grant_q      <= grant_d;
            ocup_q       <= ocup_d;
            dead_cnt_q   <= dead_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.select_salida          = sel_q;
    assign bus.habilitar              = hab_q;
    assign bus.grant                  = grant_q;
    assign bus.ocupado                = ocup_q;
    assign bus.estado                 = state_q;
    assign bus.signal_conmutacion_out = bus.In_signal_conmutacion & hab_q;

endmodule

// File: tb/tb_controlador_salida_conmutacion.sv
// Directed bench for controlador_salida_conmutacion (DEAD_TIME=4, MIN_DWELL=16).
// Each expected observation {select, habilitar, grant, ocupado} is pushed to exp_q
// before its clock edge and popped after the edge. The gated output is checked
// against a randomised raw signal on every cycle.
module tb_controlador_salida_conmutacion;

    logic clk;
    logic reset;

    controlador_salida_conmutacion_if bus ();

    controlador_salida_conmutacion #(
        .DEAD_TIME(4),
        .MIN_DWELL(16),
        .CW(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation encoding: {select, habilitar, grant[1:0], ocupado}
    localparam logic [4:0] I0 = 5'b00000;
    localparam logic [4:0] I1 = 5'b10000;
    localparam logic [4:0] D0 = 5'b00001;
    localparam logic [4:0] D1 = 5'b10001;
    localparam logic [4:0] A0 = 5'b01010;
    localparam logic [4:0] A1 = 5'b11100;

    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic in_r;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_now(input string tag);
        logic [4:0] got;
        logic [4:0] e;
        got = {bus.select_salida, bus.habilitar, bus.grant, bus.ocupado};
        e = exp_q.pop_front();
        chk(tag, got, e);
        chk({tag, "_out"}, {4'b0, bus.signal_conmutacion_out}, {4'b0, bus.In_signal_conmutacion & e[3]});
    endtask

    // Advance n clock edges; after each edge expect observation e.
    task automatic steps(input int n, input logic [4:0] e, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            @(posedge clk);
            in_r = 1'($urandom_range(0, 1));
            bus.In_signal_conmutacion = in_r;
            #1;
            check_now(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 2'b00;
        bus.In_signal_conmutacion = 1'b1;
        #4;
        exp_q.push_back(I0);
        check_now("reset_state");
        @(negedge clk);
        reset = 1'b0;
        steps(2, I0, "idle");

        // Request for channel 1 from IDLE: four dead cycles, then the grant.
        bus.req = 2'b10;
        steps(4, D1, "t2_dead");
        steps(6, A1, "t2_active");
        // The request drops at dwell 5, but the grant is held until dwell 15.
        bus.req = 2'b00;
        steps(10, A1, "t3_dwell_hold");
        steps(2, I1, "t3_idle");

        // Channel 0 runs past saturation, then the request moves to channel 1.
        bus.req = 2'b01;
        steps(4, D0, "t4_dead0");
        steps(20, A0, "t4_active0");
        bus.req = 2'b10;
        steps(4, D1, "t4_switch_dead");
        steps(3, A1, "t4_active1");

        // Both requests while channel 1 is active: a switch after dwell in either mode.
        bus.req = 2'b11;
        steps(13, A1, "pre_dwell1");
        steps(4, D0, "pre_dead0");
`ifdef SALIDA_ROUND_ROBIN_EN
        steps(16, A0, "rr_a0");
        steps(4, D1, "rr_d1");
        steps(16, A1, "rr_a1");
        steps(4, D0, "rr_d0");
        steps(16, A0, "rr_a0b");
`else
        steps(56, A0, "fp_hold0");
`endif
        bus.req = 2'b00;
        steps(1, I0, "idle_after_both");

        // Asynchronous reset while ACTIVE.
        bus.req = 2'b01;
        steps(4, D0, "t1_dead");
        steps(3, A0, "t1_active");
        #2;
        bus.In_signal_conmutacion = 1'b1;
        reset = 1'b1;
        #1;
        exp_q.push_back(I0);
        check_now("t1_async_reset");
        steps(2, I0, "t1_in_reset");
        @(negedge clk);
        bus.req = 2'b11;
        reset = 1'b0;

        // Both requests held from IDLE after reset: channel 0 wins first.
        steps(4, D0, "t5_dead0");
`ifdef SALIDA_ROUND_ROBIN_EN
        steps(16, A0, "t5_rr_a0");
        steps(4, D1, "t5_rr_d1");
        steps(16, A1, "t5_rr_a1");
        bus.req = 2'b00;
        steps(2, I1, "t5_idle");
`else
        steps(36, A0, "t5_fp_a0");
        bus.req = 2'b00;
        steps(2, I0, "t5_idle");
`endif

        // The winner drops its request during DEAD and the other channel is requesting.
        bus.req = 2'b01;
        steps(2, D0, "t6_dead0");
        bus.req = 2'b10;
        steps(2, D0, "t6_dead0_end");
        steps(4, D1, "t6_redead1");
        steps(2, A1, "t6_active1");

        // Release to IDLE after dwell. Then all requests drop during DEAD.
        bus.req = 2'b00;
        steps(14, A1, "rel_dwell");
        steps(1, I1, "rel_idle");
        bus.req = 2'b01;
        steps(1, D0, "abort_dead");
        bus.req = 2'b00;
        steps(3, D0, "abort_dead_rest");
        steps(2, I0, "abort_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
